// File: rtl/counting_gen_pkg.sv
// Shared definitions for the counting generator and the counting detector:
// state encodings and symbol values carried on the num stream.
package counting_gen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE   = 3'd1,
        TWO   = 3'd2,
        THREE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SYM_NONE  = 2'd0;
    localparam logic [1:0] SYM_ONE   = 2'd1;
    localparam logic [1:0] SYM_TWO   = 2'd2;
    localparam logic [1:0] SYM_THREE = 2'd3;

    // Symbol emitted while the generator sits in a given state.
    function automatic logic [1:0] state_sym(input state_t s);
        case (s)
            ONE:     state_sym = SYM_ONE;
            TWO:     state_sym = SYM_TWO;
            THREE:   state_sym = SYM_THREE;
            default: state_sym = SYM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/counting_gen_if.sv
// Bundle of the generator's control inputs and symbol/status outputs.
// Handshake: start is a single-cycle request sampled on a rising clk edge;
// it is accepted only in IDLE with all counts nonzero (busy rises next
// cycle), rejected with a one-cycle err pulse if any count is zero, and
// ignored in every other state. done pulses for one cycle at burst end.
interface counting_gen_if
    import counting_gen_pkg::*;
#(
    parameter int CW = 4
);
    logic          start;
    logic          pause;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic [CW-1:0] cnt3;
    logic [1:0]    num;
    logic          busy;
    logic          done;
    logic          err;
    state_t        state;

    modport master (
        output start, pause, cnt1, cnt2, cnt3,
        input  num, busy, done, err, state
    );

    modport slave (
        input  start, pause, cnt1, cnt2, cnt3,
        output num, busy, done, err, state
    );
endinterface

// File: rtl/counting_gen_phase_counter.sv
// Phase down-counter: loads a phase length, counts down once per enabled
// cycle and flags the last cycle of the phase (count == 1). It saturates
// at zero so it can never wrap.
module phase_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          term
);
    logic [CW-1:0] count;

    // Load has priority over decrement; hold at zero rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign term = (count == CW'(1));
endmodule

// File: rtl/counting_gen.sv
// Counting generator: on an accepted start emits symbol 1 for cnt1 cycles,
// symbol 2 for cnt2 cycles and symbol 3 for cnt3 cycles, then one DONE
// cycle. pause freezes the burst in place.
module counting_gen
    import counting_gen_pkg::*;
#(
    parameter int CW = 4
) (
    input logic           clk,
    input logic           reset,
    counting_gen_if.slave bus
);
    state_t        state;
    logic [CW-1:0] cnt2_q;
    logic [CW-1:0] cnt3_q;
    logic [1:0]    num_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          counts_ok;
    logic          phase_active;
    logic          load;
    logic [CW-1:0] load_val;
    logic          en;
    logic          term;

    assign counts_ok    = (bus.cnt1 != '0) && (bus.cnt2 != '0) && (bus.cnt3 != '0);
    assign phase_active = (state == ONE) || (state == TWO) || (state == THREE);

    // Counter control: load the next phase length on each phase entry.
    // cnt1 loads straight from the input; later phases use latched counts.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        en       = phase_active && !bus.pause;
        case (state)
            IDLE: begin
                load     = bus.start && counts_ok;
                load_val = bus.cnt1;
            end
            ONE: begin
                load     = en && term;
                load_val = cnt2_q;
            end
            TWO: begin
                load     = en && term;
                load_val = cnt3_q;
            end
            default: ;
        endcase
    end

    phase_counter #(.CW(CW)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .term     (term)
    );

    // Burst FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt2_q <= '0;
            cnt3_q <= '0;
            num_q  <= SYM_NONE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && counts_ok) begin
                        state  <= ONE;
                        cnt2_q <= bus.cnt2;
                        cnt3_q <= bus.cnt3;
                        num_q  <= state_sym(ONE);
                        busy_q <= 1'b1;
                    end else if (bus.start) begin
                        err_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (en && term) begin
                        state <= TWO;
                        num_q <= state_sym(TWO);
                    end
                end
                TWO: begin
                    if (en && term) begin
                        state <= THREE;
                        num_q <= state_sym(THREE);
                    end
                end
                THREE: begin
                    if (en && term) begin
                        state  <= DONE;
                        num_q  <= state_sym(DONE);
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    num_q  <= SYM_NONE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.num   = num_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.state = state;
endmodule

// File: tb/tb_counting_gen.sv
// Bench for counting_gen: directed scenarios followed by random traffic,
// checked every cycle against a queue-of-symbols reference model.
module tb_counting_gen;
    import counting_gen_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    counting_gen_if #(.CW(CW)) bus();

    counting_gen #(.CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 = idle, 1 = emitting symbols, 2 = done cycle.
    int         mode = 0;
    logic [1:0] sym_q[$];
    logic [1:0] exp_num;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
    int         busy_cycles;
    int         two_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model: the burst is a list of symbols; every
    // unpaused edge consumes one, an empty list means the done cycle.
    task automatic model_edge(input logic s, input logic p,
                              input logic [CW-1:0] a, input logic [CW-1:0] b,
                              input logic [CW-1:0] c);
        exp_err = 1'b0;
        case (mode)
            0: begin
                if (s) begin
                    if (a != 0 && b != 0 && c != 0) begin
                        sym_q.delete();
                        for (int i = 0; i < int'(a); i++) sym_q.push_back(SYM_ONE);
                        for (int i = 0; i < int'(b); i++) sym_q.push_back(SYM_TWO);
                        for (int i = 0; i < int'(c); i++) sym_q.push_back(SYM_THREE);
                        mode = 1;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
            1: begin
                if (!p) void'(sym_q.pop_front());
                if (sym_q.size() == 0) mode = 2;
            end
            default: mode = 0;
        endcase
        exp_num  = (mode == 1) ? sym_q[0] : SYM_NONE;
        exp_busy = (mode != 0);
        exp_done = (mode == 2);
    endtask

    task automatic cycle(input logic s, input logic p,
                         input logic [CW-1:0] a, input logic [CW-1:0] b,
                         input logic [CW-1:0] c);
        bus.start = s;
        bus.pause = p;
        bus.cnt1  = a;
        bus.cnt2  = b;
        bus.cnt3  = c;
        @(posedge clk);
        #1;
        model_edge(s, p, a, b, c);
        check("num",  32'(bus.num),  32'(exp_num));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("done", 32'(bus.done), 32'(exp_done));
        check("err",  32'(bus.err),  32'(exp_err));
        if (bus.busy === 1'b1) busy_cycles++;
        if (bus.num === SYM_TWO) two_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.cnt1  = '0;
        bus.cnt2  = '0;
        bus.cnt3  = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_num",   32'(bus.num),   32'(SYM_NONE));
        check("rst_busy",  32'(bus.busy),  32'(0));
        check("rst_done",  32'(bus.done),  32'(0));
        check("rst_err",   32'(bus.err),   32'(0));
        check("rst_state", 32'(bus.state), 32'(IDLE));
        reset = 1'b0;

        // Minimal burst 1,1,1.
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'd1, 4'd1, 4'd1);
        idle(5);
        check("min_busy", 32'(busy_cycles), 32'(4));

        // Long burst 3,2,4: nine symbols plus the done cycle.
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'd3, 4'd2, 4'd4);
        idle(11);
        check("long_busy", 32'(busy_cycles), 32'(10));

        // Rejected start: a zero count.
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'd2, 4'd0, 4'd1);
        idle(3);
        check("rej_busy", 32'(busy_cycles), 32'(0));

        // Pause for three cycles during TWO.
        busy_cycles = 0;
        two_cycles  = 0;
        cycle(1'b1, 1'b0, 4'd2, 4'd2, 4'd2);
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(8);
        check("pause_two",  32'(two_cycles),  32'(5));
        check("pause_busy", 32'(busy_cycles), 32'(10));

        // Asynchronous reset in THREE, then a fresh burst.
        cycle(1'b1, 1'b0, 4'd2, 4'd2, 4'd2);
        idle(4);
        check("mid_state", 32'(bus.state), 32'(THREE));
        #2;
        reset = 1'b1;
        #1;
        check("arst_num",   32'(bus.num),   32'(SYM_NONE));
        check("arst_busy",  32'(bus.busy),  32'(0));
        check("arst_state", 32'(bus.state), 32'(IDLE));
        mode = 0;
        sym_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'd1, 4'd2, 4'd1);
        idle(6);
        check("post_rst_busy", 32'(busy_cycles), 32'(5));

        // Start held high with changing counts during a burst and its DONE.
        cycle(1'b1, 1'b0, 4'd2, 4'd3, 4'd1);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        idle(50);

        // Maximum burst.
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'd15, 4'd15, 4'd15);
        idle(47);
        check("max_busy", 32'(busy_cycles), 32'(46));

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                  4'($urandom_range(0, 4)));
        idle(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counting_gen.md
COUNTING_GEN -- requirements
Module: counting_gen

Interface
REQ-001 Parameter CW, default 4: width of each repeat-count input and of the internal phase counter.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request to emit one burst; sampled on a clk edge.
REQ-005 Port cnt1, input, CW: number of cycles to emit symbol 1.
REQ-006 Port cnt2, input, CW: number of cycles to emit symbol 2.
REQ-007 Port cnt3, input, CW: number of cycles to emit symbol 3.
REQ-008 Port pause, input, 1: freeze the burst in place while high.
REQ-009 Port num, output, 2: emitted symbol stream; 0 means no symbol; feeds the counting detector's num input.
REQ-010 Port busy, output, 1: high from the cycle after an accepted start until the done cycle, inclusive.
REQ-011 Port done, output, 1: one-cycle pulse marking the end of a burst.
REQ-012 Port err, output, 1: one-cycle pulse marking a rejected start.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States SHALL be IDLE, ONE, TWO, THREE and DONE.
- num values: IDLE 0, ONE 1, TWO 2, THREE 3, DONE 0.
REQ-015 In IDLE, start=1 with cnt1, cnt2 and cnt3 all nonzero SHALL latch all three counts and move to ONE.
- num=1 and busy=1 from the next cycle (latency 1).
REQ-016 In IDLE, start=1 with any count equal to 0 SHALL:
- pulse err=1 for exactly one cycle;
- remain in IDLE with num=0.
REQ-017 start SHALL be ignored in every state other than IDLE.
- No err pulse.
- Latched counts are unchanged.
REQ-018 Phase length SHALL equal the latched count, i.e. ONE lasts cnt1 unpaused cycles, TWO lasts cnt2 and THREE lasts cnt3.
- Transitions: ONE to TWO, TWO to THREE, THREE to DONE.
REQ-019 Changes on cnt1, cnt2 and cnt3 after acceptance SHALL have no effect on the burst in progress.
REQ-020 The phase counter SHALL:
- load the next phase's count on each phase entry;
- decrement once per unpaused cycle;
- transition when it reaches 1;
- never wrap.
REQ-021 While pause=1 in ONE, TWO or THREE, state, counter and num SHALL hold.
- Paused cycles extend the current phase.
- The detector tolerates repeated symbols.
REQ-022 pause SHALL have no effect in IDLE or DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=1 and num=0, then return to IDLE.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new burst can be accepted no earlier than the first IDLE cycle.
REQ-025 The maximum burst is 3*(2^CW-1) unpaused symbol cycles; no arithmetic SHALL overflow.

Reset
REQ-026 reset=1 SHALL force IDLE immediately, independent of clk, from any state including mid-burst.
- Outputs forced: num=0, busy=0, done=0, err=0.
- Counter and latched counts cleared to 0.
REQ-027 After reset is released, the block SHALL require a fresh start; an interrupted burst is not resumed.

Structure
REQ-028 A shared package SHALL hold:
- the state encodings IDLE..DONE;
- the symbol constants SYM_NONE=0, SYM_ONE=1, SYM_TWO=2, SYM_THREE=3;
- these constants shared with the counting detector.
REQ-029 The phase down-counter SHALL be one sub-module, phase_counter.
- Inputs: load, load value, enable (not paused).
- Output: terminal flag (count==1).

Verification
REQ-030 Minimal burst: cnt=1,1,1, start at cycle 0 -> num=1,2,3 on cycles 1-3, done=1 on cycle 4; detector ans=1 on the edge after it samples num=3.
REQ-031 Long burst: cnt=3,2,4 -> num sequence 1,1,1,2,2,3,3,3,3, then num=0 with done=1; busy high for 10 cycles.
REQ-032 Reject: cnt=2,0,1 with start -> err=1 for 1 cycle, num stays 0, busy stays 0.
REQ-033 Pause: cnt=2,2,2 with pause high for 3 cycles during TWO -> num=2 for 5 cycles; total busy = 10 cycles.
REQ-034 Reset mid-burst: assert reset in THREE -> num=0 and busy=0 immediately; start is accepted again after reset is released.
REQ-035 Start while busy, and counts changed mid-burst -> ignored; the original burst completes unchanged.
